interrupt_sequencer: RTL and testbench
======================================

INTERRUPT_SEQUENCER -- requirements
Module: interrupt_sequencer

Interface
REQ-001 CLK  input  1  system clock; all state changes on rising edge.
REQ-002 RESET  input  1  asynchronous, active-high reset; one clock domain only.
REQ-003 FETCH  input  1  fetch-phase strobe; decisions are taken only in cycles where FETCH=1.
REQ-004 INT_EN  input  1  global interrupt enable; gates interrupt entry only, never RETI.
REQ-005 INT0_REQ  input  1  level request, highest priority.
REQ-006 INT1_REQ  input  1  level request, lower priority.
REQ-007 RETI  input  1  decoded return-from-interrupt; acted on when RETI=1 and FETCH=1.
REQ-008 PC_NEXTX  output  3  next-address select: 0=NEXT, 1=INTV0, 2=INTV1, 3=INTR0, 4=INTR1.
REQ-009 PC_LD_INT0X  output  1  saves the return address into the INT0 register.
REQ-010 PC_LD_INT1X  output  1  saves the return address into the INT1 register.
REQ-011 INT0_ACK, INT1_ACK  output  1 each  one-cycle registered acknowledge pulse.
REQ-012 IN_INT0, IN_INT1  output  1 each  in-service flags.

Function
REQ-013 Each request is registered every clock (REQ_Q); a rising edge (REQ=1, REQ_Q=0) sets the matching pending flag.
REQ-014 A pending flag clears only on entry to its handler; if a new edge and the clear coincide, the flag stays set.
REQ-015 State machine states: IDLE, SVC1, SVC0, SVC0_NEST (INT0 preempting INT1); IN_INT0=1 in SVC0/SVC0_NEST, IN_INT1=1 in SVC1/SVC0_NEST.
REQ-016 The decision is combinational from state, pending, INT_EN, RETI and FETCH, in priority order RETI > entry0 > entry1 > NEXT.
REQ-017 RETI&FETCH: SVC0 -> IDLE, PC_NEXTX=3; SVC0_NEST -> SVC1, PC_NEXTX=3; SVC1 -> IDLE, PC_NEXTX=4; IDLE -> IDLE, PC_NEXTX=0 (ignored).
REQ-018 Entry0 occurs when FETCH, INT_EN, pend0 and state is IDLE or SVC1: PC_NEXTX=1, PC_LD_INT0X=1, IDLE->SVC0, SVC1->SVC0_NEST, pend0 cleared.
REQ-019 Entry1 occurs when FETCH, INT_EN, pend1, no entry0 and state is IDLE: PC_NEXTX=2, PC_LD_INT1X=1, IDLE->SVC1, pend1 cleared.
REQ-020 INT1 never preempts INT0, and neither source preempts itself; blocked requests stay pending.
REQ-021 If RETI and an entry are both eligible in one fetch, only RETI is taken; the pending flag is kept and enters on a later fetch.
REQ-022 With FETCH=0, outputs are PC_NEXTX=0 and PC_LD_INT*X=0, and state and pending hold (except edge capture).
REQ-023 PC_LD_INT0X and PC_LD_INT1X are never both 1, and each is 1 only in the entry cycle.
REQ-024 INTx_ACK is 1 for exactly the clock after the corresponding entry.
REQ-025 Clearing INT_EN does not clear pending flags or in-service state.

Reset
REQ-026 On RESET assertion, the block enters IDLE immediately, regardless of clock.
REQ-027 On RESET, pend0, pend1, REQ_Q and both ACKs clear to 0, and PC_NEXTX=0, PC_LD_INT*X=0.
REQ-028 A reset mid-handler discards all nesting; the first fetch after release with no RETI or pending flag yields PC_NEXTX=0.
REQ-029 A request held high across reset release is not seen as an edge until it drops and rises again.

Verification
REQ-030 The bench shall cover INT_EN=1, IDLE, INT1_REQ edge, then fetch -> PC_NEXTX=2, PC_LD_INT1X=1, IN_INT1=1, INT1_ACK pulse next clock.
REQ-031 The bench shall cover SVC1, INT0 edge, then fetch -> PC_NEXTX=1, PC_LD_INT0X=1, state SVC0_NEST; RETI -> PC_NEXTX=3 (SVC1); RETI -> PC_NEXTX=4 (IDLE).
REQ-032 The bench shall cover SVC0 with an INT1 edge -> no entry while in SVC0; RETI fetch -> PC_NEXTX=3; next fetch -> PC_NEXTX=2.
REQ-033 The bench shall cover simultaneous INT0 and INT1 edges in IDLE -> first fetch gives PC_NEXTX=1, and INT1 waits until after RETI.
REQ-034 The bench shall cover INT_EN=0 with an INT0 edge -> PC_NEXTX=0 on all fetches; raising INT_EN -> entry on the next fetch.
REQ-035 The bench shall cover RESET pulsed in SVC0_NEST -> IN_INT0=IN_INT1=0, and RETI fetch -> PC_NEXTX=0.

Source files
------------

// File: rtl/interrupt_sequencer.sv
// Two-level interrupt sequencer: edge-captured requests, fixed priority (INT0 over INT1),
// INT0 may nest over INT1, and next-PC select / return-address load strobes per fetch.
module interrupt_sequencer (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       FETCH,
    input  logic       INT_EN,
    input  logic       INT0_REQ,
    input  logic       INT1_REQ,
    input  logic       RETI,
    output logic [2:0] PC_NEXTX,
    output logic       PC_LD_INT0X,
    output logic       PC_LD_INT1X,
    output logic       INT0_ACK,
    output logic       INT1_ACK,
    output logic       IN_INT0,
    output logic       IN_INT1
);

    localparam logic [2:0] SEL_NEXT  = 3'd0;
    localparam logic [2:0] SEL_INTV0 = 3'd1;
    localparam logic [2:0] SEL_INTV1 = 3'd2;
    localparam logic [2:0] SEL_INTR0 = 3'd3;
    localparam logic [2:0] SEL_INTR1 = 3'd4;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_SVC1      = 2'd1,
        ST_SVC0      = 2'd2,
        ST_SVC0_NEST = 2'd3
    } state_t;

    state_t     state_r;
    state_t     state_next_s;
    logic       req0_q_r;
    logic       req1_q_r;
    logic       primed_r;
    logic       pend0_r;
    logic       pend1_r;
    logic       ack0_r;
    logic       ack1_r;
    logic       in_int0_r;
    logic       in_int1_r;
    logic       edge0_s;
    logic       edge1_s;
    logic       clr0_s;
    logic       clr1_s;
    logic       ld0_s;
    logic       ld1_s;
    logic [2:0] pc_nextx_s;

    // primed_r masks the first post-reset sample so a request held across release is not an edge
    assign edge0_s = INT0_REQ & ~req0_q_r & primed_r;
    assign edge1_s = INT1_REQ & ~req1_q_r & primed_r;

    // Fetch-time decision: RETI, then INT0 entry, then INT1 entry, else sequential
    always_comb begin
        state_next_s = state_r;
        pc_nextx_s   = SEL_NEXT;
        ld0_s        = 1'b0;
        ld1_s        = 1'b0;
        clr0_s       = 1'b0;
        clr1_s       = 1'b0;
        if (FETCH) begin
            if (RETI) begin
                case (state_r)
                    ST_SVC0: begin
                        state_next_s = ST_IDLE;
                        pc_nextx_s   = SEL_INTR0;
                    end
                    ST_SVC0_NEST: begin
                        state_next_s = ST_SVC1;
                        pc_nextx_s   = SEL_INTR0;
                    end
                    ST_SVC1: begin
                        state_next_s = ST_IDLE;
                        pc_nextx_s   = SEL_INTR1;
                    end
                    default: begin
                        state_next_s = ST_IDLE;
                        pc_nextx_s   = SEL_NEXT;
                    end
                endcase
            end else if (INT_EN && pend0_r && (state_r == ST_IDLE || state_r == ST_SVC1)) begin
                pc_nextx_s   = SEL_INTV0;
                ld0_s        = 1'b1;
                clr0_s       = 1'b1;
                state_next_s = (state_r == ST_SVC1) ? ST_SVC0_NEST : ST_SVC0;
            end else if (INT_EN && pend1_r && state_r == ST_IDLE) begin
                pc_nextx_s   = SEL_INTV1;
                ld1_s        = 1'b1;
                clr1_s       = 1'b1;
                state_next_s = ST_SVC1;
            end else begin
                pc_nextx_s   = SEL_NEXT;
            end
        end else begin
            pc_nextx_s   = SEL_NEXT;
        end
    end

    // State, request history, pending flags and registered status outputs
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_r   <= ST_IDLE;
            req0_q_r  <= 1'b0;
            req1_q_r  <= 1'b0;
            primed_r  <= 1'b0;
            pend0_r   <= 1'b0;
            pend1_r   <= 1'b0;
            ack0_r    <= 1'b0;
            ack1_r    <= 1'b0;
            in_int0_r <= 1'b0;
            in_int1_r <= 1'b0;
        end else begin
            state_r   <= state_next_s;
            req0_q_r  <= INT0_REQ;
            req1_q_r  <= INT1_REQ;
            primed_r  <= 1'b1;
            // a fresh edge wins over a coincident clear
            pend0_r   <= (pend0_r & ~clr0_s) | edge0_s;
            pend1_r   <= (pend1_r & ~clr1_s) | edge1_s;
            ack0_r    <= ld0_s;
            ack1_r    <= ld1_s;
            in_int0_r <= (state_next_s == ST_SVC0) || (state_next_s == ST_SVC0_NEST);
            in_int1_r <= (state_next_s == ST_SVC1) || (state_next_s == ST_SVC0_NEST);
        end
    end

    assign PC_NEXTX    = pc_nextx_s;
    assign PC_LD_INT0X = ld0_s;
    assign PC_LD_INT1X = ld1_s;
    assign INT0_ACK    = ack0_r;
    assign INT1_ACK    = ack1_r;
    assign IN_INT0     = in_int0_r;
    assign IN_INT1     = in_int1_r;

endmodule

// File: tb/tb_interrupt_sequencer.sv
// Scenario bench for interrupt_sequencer: fetch decisions go through an expectation queue,
// status flags are compared inline per scenario.
module tb_interrupt_sequencer;

    logic       CLK = 1'b0;
    logic       RESET = 1'b1;
    logic       FETCH = 1'b0;
    logic       INT_EN = 1'b0;
    logic       INT0_REQ = 1'b0;
    logic       INT1_REQ = 1'b0;
    logic       RETI = 1'b0;
    logic [2:0] PC_NEXTX;
    logic       PC_LD_INT0X;
    logic       PC_LD_INT1X;
    logic       INT0_ACK;
    logic       INT1_ACK;
    logic       IN_INT0;
    logic       IN_INT1;

    typedef struct {
        string      name;
        logic [2:0] nextx;
        logic       ld0;
        logic       ld1;
    } exp_t;

    exp_t exp_q[$];
    int   total_cnt = 0;
    int   pass_cnt  = 0;

    interrupt_sequencer dut (
        .CLK(CLK), .RESET(RESET), .FETCH(FETCH), .INT_EN(INT_EN),
        .INT0_REQ(INT0_REQ), .INT1_REQ(INT1_REQ), .RETI(RETI),
        .PC_NEXTX(PC_NEXTX), .PC_LD_INT0X(PC_LD_INT0X), .PC_LD_INT1X(PC_LD_INT1X),
        .INT0_ACK(INT0_ACK), .INT1_ACK(INT1_ACK), .IN_INT0(IN_INT0), .IN_INT1(IN_INT1)
    );

    always #5 CLK = ~CLK;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    // All tasks start and end just after a falling edge.
    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge CLK);
            @(negedge CLK);
        end
    endtask

    // Drive one fetch cycle; the expected decision is queued now and checked from the queue.
    task automatic fetch(input string name, input logic reti, input logic [2:0] nx,
                         input logic l0, input logic l1);
        exp_t e;
        exp_t g;
        e.name = name; e.nextx = nx; e.ld0 = l0; e.ld1 = l1;
        exp_q.push_back(e);
        FETCH = 1'b1;
        RETI  = reti;
        #1;
        total_cnt++;
        if (exp_q.size() == 0) begin
            $display("FAIL %s: scoreboard empty, expected one entry", name);
        end else begin
            g = exp_q.pop_front();
            if ({PC_NEXTX, PC_LD_INT0X, PC_LD_INT1X} !== {g.nextx, g.ld0, g.ld1})
                $display("FAIL %s: PC_NEXTX=%0d LD0=%b LD1=%b, expected %0d %b %b",
                         g.name, PC_NEXTX, PC_LD_INT0X, PC_LD_INT1X, g.nextx, g.ld0, g.ld1);
            else
                pass_cnt++;
        end
        @(posedge CLK);
        @(negedge CLK);
        FETCH = 1'b0;
        RETI  = 1'b0;
    endtask

    task automatic test_reset;
        RESET = 1'b1;
        tick(2);
        total_cnt++;
        if ({PC_NEXTX, PC_LD_INT0X, PC_LD_INT1X, INT0_ACK, INT1_ACK, IN_INT0, IN_INT1} !== 9'b0)
            $display("FAIL reset_outputs: got %b, expected %b",
                     {PC_NEXTX, PC_LD_INT0X, PC_LD_INT1X, INT0_ACK, INT1_ACK, IN_INT0, IN_INT1}, 9'b0);
        else
            pass_cnt++;
        RESET = 1'b0;
        tick(2);
        fetch("reset_first_fetch", 1'b0, 3'd0, 1'b0, 1'b0);
    endtask

    task automatic test_int1_entry;
        INT_EN = 1'b1;
        INT1_REQ = 1'b1;
        tick(1);
        total_cnt++;
        if ({PC_NEXTX, PC_LD_INT1X} !== {3'd0, 1'b0})
            $display("FAIL int1_nofetch: PC_NEXTX=%0d LD1=%b, expected 0 0", PC_NEXTX, PC_LD_INT1X);
        else
            pass_cnt++;
        fetch("int1_entry", 1'b0, 3'd2, 1'b0, 1'b1);
        total_cnt++;
        if ({IN_INT0, IN_INT1, INT0_ACK, INT1_ACK} !== 4'b0101)
            $display("FAIL int1_flags: got %b, expected %b", {IN_INT0, IN_INT1, INT0_ACK, INT1_ACK}, 4'b0101);
        else
            pass_cnt++;
        tick(1);
        total_cnt++;
        if ({INT0_ACK, INT1_ACK} !== 2'b00)
            $display("FAIL int1_ack_pulse: got %b, expected %b", {INT0_ACK, INT1_ACK}, 2'b00);
        else
            pass_cnt++;
    endtask

    task automatic test_nesting;
        INT0_REQ = 1'b1;
        tick(1);
        fetch("nest_entry0", 1'b0, 3'd1, 1'b1, 1'b0);
        total_cnt++;
        if ({IN_INT0, IN_INT1, INT0_ACK, INT1_ACK} !== 4'b1110)
            $display("FAIL nest_flags: got %b, expected %b", {IN_INT0, IN_INT1, INT0_ACK, INT1_ACK}, 4'b1110);
        else
            pass_cnt++;
        fetch("nest_reti0", 1'b1, 3'd3, 1'b0, 1'b0);
        total_cnt++;
        if ({IN_INT0, IN_INT1} !== 2'b01)
            $display("FAIL nest_back_svc1: got %b, expected %b", {IN_INT0, IN_INT1}, 2'b01);
        else
            pass_cnt++;
        fetch("nest_reti1", 1'b1, 3'd4, 1'b0, 1'b0);
        total_cnt++;
        if ({IN_INT0, IN_INT1} !== 2'b00)
            $display("FAIL nest_back_idle: got %b, expected %b", {IN_INT0, IN_INT1}, 2'b00);
        else
            pass_cnt++;
        fetch("idle_reti_ignored", 1'b1, 3'd0, 1'b0, 1'b0);
        INT0_REQ = 1'b0;
        INT1_REQ = 1'b0;
        tick(1);
    endtask

    task automatic test_int1_blocked;
        INT0_REQ = 1'b1;
        tick(1);
        fetch("blk_entry0", 1'b0, 3'd1, 1'b1, 1'b0);
        INT1_REQ = 1'b1;
        tick(1);
        fetch("blk_no_preempt", 1'b0, 3'd0, 1'b0, 1'b0);
        fetch("blk_reti0", 1'b1, 3'd3, 1'b0, 1'b0);
        fetch("blk_late_entry1", 1'b0, 3'd2, 1'b0, 1'b1);
        fetch("blk_reti1", 1'b1, 3'd4, 1'b0, 1'b0);
        INT0_REQ = 1'b0;
        INT1_REQ = 1'b0;
        tick(1);
    endtask

    task automatic test_simultaneous;
        INT0_REQ = 1'b1;
        INT1_REQ = 1'b1;
        tick(1);
        fetch("sim_first0", 1'b0, 3'd1, 1'b1, 1'b0);
        fetch("sim_wait1", 1'b0, 3'd0, 1'b0, 1'b0);
        fetch("sim_reti0", 1'b1, 3'd3, 1'b0, 1'b0);
        fetch("sim_then1", 1'b0, 3'd2, 1'b0, 1'b1);
        fetch("sim_reti1", 1'b1, 3'd4, 1'b0, 1'b0);
        INT0_REQ = 1'b0;
        INT1_REQ = 1'b0;
        tick(1);
    endtask

    task automatic test_reti_over_entry;
        INT1_REQ = 1'b1;
        tick(1);
        fetch("roe_entry1", 1'b0, 3'd2, 1'b0, 1'b1);
        INT0_REQ = 1'b1;
        tick(1);
        fetch("roe_reti_wins", 1'b1, 3'd4, 1'b0, 1'b0);
        fetch("roe_entry0_later", 1'b0, 3'd1, 1'b1, 1'b0);
        total_cnt++;
        if ({IN_INT0, IN_INT1} !== 2'b10)
            $display("FAIL roe_svc0: got %b, expected %b", {IN_INT0, IN_INT1}, 2'b10);
        else
            pass_cnt++;
        fetch("roe_reti0", 1'b1, 3'd3, 1'b0, 1'b0);
        INT0_REQ = 1'b0;
        INT1_REQ = 1'b0;
        tick(1);
    endtask

    task automatic test_int_en;
        INT_EN = 1'b0;
        INT0_REQ = 1'b1;
        tick(1);
        fetch("en0_fetch_a", 1'b0, 3'd0, 1'b0, 1'b0);
        fetch("en0_fetch_b", 1'b0, 3'd0, 1'b0, 1'b0);
        INT_EN = 1'b1;
        fetch("en1_entry0", 1'b0, 3'd1, 1'b1, 1'b0);
        INT_EN = 1'b0;
        fetch("en0_reti_allowed", 1'b1, 3'd3, 1'b0, 1'b0);
        INT_EN = 1'b1;
        INT0_REQ = 1'b0;
        tick(1);
    endtask

    task automatic test_reset_mid_handler;
        INT1_REQ = 1'b1;
        tick(1);
        fetch("rst_entry1", 1'b0, 3'd2, 1'b0, 1'b1);
        INT0_REQ = 1'b1;
        tick(1);
        fetch("rst_entry0", 1'b0, 3'd1, 1'b1, 1'b0);
        #2;
        RESET = 1'b1;
        #1;
        total_cnt++;
        if ({IN_INT0, IN_INT1, INT0_ACK, INT1_ACK} !== 4'b0000)
            $display("FAIL rst_async_clear: got %b, expected %b", {IN_INT0, IN_INT1, INT0_ACK, INT1_ACK}, 4'b0000);
        else
            pass_cnt++;
        @(negedge CLK);
        tick(1);
        RESET = 1'b0;
        tick(1);
        fetch("rst_reti_ignored", 1'b1, 3'd0, 1'b0, 1'b0);
        fetch("rst_held_not_edge", 1'b0, 3'd0, 1'b0, 1'b0);
        INT0_REQ = 1'b0;
        tick(1);
        INT0_REQ = 1'b1;
        tick(1);
        fetch("rst_new_edge0", 1'b0, 3'd1, 1'b1, 1'b0);
        fetch("rst_reti0", 1'b1, 3'd3, 1'b0, 1'b0);
        fetch("rst_held1_quiet", 1'b0, 3'd0, 1'b0, 1'b0);
        INT0_REQ = 1'b0;
        INT1_REQ = 1'b0;
        tick(1);
    endtask

    initial begin
        @(negedge CLK);
        test_reset();
        test_int1_entry();
        test_nesting();
        test_int1_blocked();
        test_simultaneous();
        test_reti_over_entry();
        test_int_en();
        test_reset_mid_handler();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
